// File: rtl/m31_ext_mix16.sv
// Poseidon2 external-layer outer circulant over M31 (p = 2^31-1).
// Input lanes have already passed through the per-block 4x4 MDS; this block
// adds to every lane the column sum of its lane position within the 4-lane blocks:
//   y[i] = x[i] + s[i mod 4],  s[j] = sum_k x[4k+j]   (mod p)
// Two-stage valid/ready pipeline with full backpressure and a pass-through tag.
module m31_ext_mix16 #(
  parameter int T     = 16,
  parameter int TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [T*31-1:0]    in_state,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [T*31-1:0]    out_state,
  output logic [TAG_W-1:0]   out_tag
);

  localparam logic [30:0] P   = 31'h7FFF_FFFF;
  localparam int          BLK = T / 4;

  // Modular add for operands in [0, p]: the 2^31 carry is worth 1 mod p, so it
  // folds back into bit 0; a result of exactly p is the non-canonical zero.
  // Operands equal to p therefore behave as 0 and the result is always canonical.
  function automatic logic [30:0] madd(input logic [30:0] a, input logic [30:0] b);
    logic [31:0] sum;
    logic [30:0] r;
    sum = {1'b0, a} + {1'b0, b};
    r   = sum[30:0] + {30'd0, sum[31]};
    return (r == P) ? 31'd0 : r;
  endfunction

  // Stage registers: _p1 holds the raw state plus its column sums, _p2 the mixed result.
  logic                 vld_p1_q, vld_p1_d;
  logic                 vld_p2_q, vld_p2_d;
  logic [T*31-1:0]      x_p1_q,   x_p1_d;
  logic [3:0][30:0]     s_p1_q,   s_p1_d;
  logic [TAG_W-1:0]     tag_p1_q, tag_p1_d;
  logic [T*31-1:0]      y_p2_q,   y_p2_d;
  logic [TAG_W-1:0]     tag_p2_q, tag_p2_d;

  logic                 s1_load;
  logic                 s2_load;
  logic [3:0][30:0]     col_sum;
  logic [T*31-1:0]      y_mix;

  // Handshake: S2 refills when empty or draining; S1 accepts when empty or moving on.
  always_comb begin
    s2_load  = vld_p1_q && (!vld_p2_q || out_ready);
    in_ready = !vld_p1_q || s2_load;
    s1_load  = in_valid && in_ready;
  end

  // Column sums of the incoming state, one madd chain per lane position j.
  always_comb begin
    col_sum = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < BLK; k++) begin
        col_sum[j] = madd(col_sum[j], in_state[31*(4*k+j) +: 31]);
      end
    end
  end

  // Outer circulant: each registered lane plus the sum for its column.
  always_comb begin
    y_mix = '0;
    for (int i = 0; i < T; i++) begin
      y_mix[31*i +: 31] = madd(x_p1_q[31*i +: 31], s_p1_q[i % 4]);
    end
  end

  // Next-state selection for both stages; registers hold when not loaded.
  always_comb begin
    x_p1_d   = s1_load ? in_state : x_p1_q;
    s_p1_d   = s1_load ? col_sum  : s_p1_q;
    tag_p1_d = s1_load ? in_tag   : tag_p1_q;
    vld_p1_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : vld_p1_q);

    y_p2_d   = s2_load ? y_mix    : y_p2_q;
    tag_p2_d = s2_load ? tag_p1_q : tag_p2_q;
    vld_p2_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : vld_p2_q);
  end

  // Pipeline registers; reset clears valids and data so outputs read as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      x_p1_q   <= '0;
      s_p1_q   <= '0;
      tag_p1_q <= '0;
      y_p2_q   <= '0;
      tag_p2_q <= '0;
    end else begin
      // ---- stage 1: capture input state, tag and column sums
      vld_p1_q <= vld_p1_d;
      x_p1_q   <= x_p1_d;
      s_p1_q   <= s_p1_d;
      tag_p1_q <= tag_p1_d;
      // ---- stage 2: capture mixed state, drives the output port
      vld_p2_q <= vld_p2_d;
      y_p2_q   <= y_p2_d;
      tag_p2_q <= tag_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_state = y_p2_q;
  assign out_tag   = tag_p2_q;

endmodule

// File: tb/tb_m31_ext_mix16.sv
// Self-checking bench for m31_ext_mix16: a scoreboard of expected outputs built
// from a plain integer model of the outer circulant, checked on every output
// transfer, plus directed cases with hand-computed values.
module tb_m31_ext_mix16;
  localparam int T     = 16;
  localparam int TAG_W = 8;
  localparam int W     = T * 31;
  localparam longint P = 64'h7FFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_state;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_state;
  logic [TAG_W-1:0] out_tag;

  m31_ext_mix16 #(.T(T), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  bit lat2_mode = 0;

  typedef struct {
    logic [W-1:0]     st;
    logic [TAG_W-1:0] tg;
    int               cyc;
  } exp_t;
  exp_t q[$];

  logic [W-1:0]     last_st;
  logic [TAG_W-1:0] last_tg;
  logic [W-1:0]     prev_st;
  logic [TAG_W-1:0] prev_tg;
  bit               hold_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (act running, req finished)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: integer column sums and lane adds reduced with %, lanes equal to p count as 0.
  function automatic logic [W-1:0] mix(input logic [W-1:0] x);
    longint s[4];
    longint v;
    logic [W-1:0] y;
    for (int j = 0; j < 4; j++) s[j] = 0;
    for (int i = 0; i < T; i++) begin
      v = longint'(x[31*i +: 31]);
      s[i % 4] = s[i % 4] + v;
    end
    for (int j = 0; j < 4; j++) s[j] = s[j] % P;
    y = '0;
    for (int i = 0; i < T; i++) begin
      v = (longint'(x[31*i +: 31]) + s[i % 4]) % P;
      y[31*i +: 31] = v[30:0];
    end
    return y;
  endfunction

  function automatic logic [30:0] lane(input logic [W-1:0] st, input int i);
    return st[31*i +: 31];
  endfunction

  function automatic logic [W-1:0] rand_state();
    logic [W-1:0] st;
    for (int i = 0; i < T; i++) begin
      st[31*i +: 31] = ($urandom_range(0, 7) == 0) ? 31'h7FFF_FFFF : 31'($urandom % 32'h7FFF_FFFF);
    end
    return st;
  endfunction

  // Scoreboard monitor, sampled on the falling edge: predicts transfers at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("hold_state", out_state, prev_st);
        chk("hold_tag", W'(out_tag), W'(prev_tg));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got tag %h with nothing expected", out_tag);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_state", out_state, e.st);
          chk("out_tag", W'(out_tag), W'(e.tg));
          if (lat2_mode) chk_i("latency", cyc - e.cyc, 2);
          last_st = out_state;
          last_tg = out_tag;
          n_out++;
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_st   = out_state;
      prev_tg   = out_tag;
      if (in_valid && in_ready) begin
        q.push_back('{st: mix(in_state), tg: in_tag, cyc: cyc});
        n_acc++;
      end
    end
  end

  task automatic push(input logic [W-1:0] st, input logic [TAG_W-1:0] tg);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_state = st;
    in_tag   = tg;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: in_ready stayed 0, required 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d states still pending, required 0", q.size());
    end
  endtask

  logic [W-1:0] st;
  logic [W-1:0] m;
  logic [W-1:0] stall_st[4];
  int a0, o0, idx, acc, n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_tag = '0; out_ready = 1'b1;

    // Pin the model with hand-computed values.
    for (int i = 0; i < T; i++) st[31*i +: 31] = 31'd1;
    m = mix(st);
    chk("model_ones_y0", W'(lane(m, 0)), W'(5));
    chk("model_ones_y13", W'(lane(m, 13)), W'(5));
    st = '0; st[30:0] = 31'h7FFF_FFFE;
    m = mix(st);
    chk("model_pm1_y0", W'(lane(m, 0)), W'(31'h7FFF_FFFD));
    chk("model_pm1_y8", W'(lane(m, 8)), W'(31'h7FFF_FFFE));
    chk("model_pm1_y1", W'(lane(m, 1)), W'(0));
    for (int i = 0; i < T; i++) st[31*i +: 31] = 31'(i);
    m = mix(st);
    chk("model_idx_y0", W'(lane(m, 0)), W'(24));
    chk("model_idx_y15", W'(lane(m, 15)), W'(51));

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_state", out_state, '0);
    chk("rst_out_tag", W'(out_tag), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;

    // All lanes 1 -> every lane 5, with a 2-cycle latency.
    lat2_mode = 1;
    for (int i = 0; i < T; i++) st[31*i +: 31] = 31'd1;
    push(st, 8'h05);
    drain();
    for (int i = 0; i < T; i++) chk("ones_lane", W'(lane(last_st, i)), W'(5));
    chk("ones_tag", W'(last_tg), W'(8'h05));

    // Lane 0 = p-1, rest 0.
    st = '0; st[30:0] = 31'h7FFF_FFFE;
    push(st, 8'h11);
    drain();
    chk("pm1_y0", W'(lane(last_st, 0)), W'(31'h7FFF_FFFD));
    chk("pm1_y4", W'(lane(last_st, 4)), W'(31'h7FFF_FFFE));
    chk("pm1_y12", W'(lane(last_st, 12)), W'(31'h7FFF_FFFE));
    chk("pm1_y5", W'(lane(last_st, 5)), W'(0));

    // Lane i = i.
    for (int i = 0; i < T; i++) st[31*i +: 31] = 31'(i);
    push(st, 8'h22);
    drain();
    chk("idx_y0", W'(lane(last_st, 0)), W'(24));
    chk("idx_y6", W'(lane(last_st, 6)), W'(38));
    chk("idx_y15", W'(lane(last_st, 15)), W'(51));

    // Lane 3 = p (treated as 0), rest 1: column 3 sum = 3.
    for (int i = 0; i < T; i++) st[31*i +: 31] = 31'd1;
    st[31*3 +: 31] = 31'h7FFF_FFFF;
    push(st, 8'h33);
    drain();
    chk("p_in_y3", W'(lane(last_st, 3)), W'(3));
    chk("p_in_y7", W'(lane(last_st, 7)), W'(4));
    chk("p_in_y0", W'(lane(last_st, 0)), W'(5));

    // Back-to-back stream of 8 states, out_ready held high.
    o0 = n_out;
    for (int i = 0; i < 8; i++) push(rand_state(), 8'(8'h40 + i));
    drain();
    lat2_mode = 0;
    chk_i("stream_count", n_out - o0, 8);
    chk("stream_last_tag", W'(last_tg), W'(8'h47));

    // Stall: out_ready low for 5 cycles with input always offered.
    for (int i = 0; i < 4; i++) stall_st[i] = rand_state();
    a0 = n_acc; o0 = n_out; idx = 0; n = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = stall_st[0]; in_tag = 8'h30;
    repeat (5) begin
      @(negedge clk); acc = int'(in_ready);
      @(posedge clk); #1;
      if (acc != 0) begin idx++; in_state = stall_st[idx]; in_tag = 8'(8'h30 + idx); end
    end
    chk_i("stall_accepts", n_acc - a0, 2);
    chk("stall_in_ready", W'(in_ready), W'(0));
    chk("stall_out_valid", W'(out_valid), W'(1));
    out_ready = 1'b1;
    while (idx < 4 && n < 50) begin
      @(negedge clk); acc = int'(in_ready);
      @(posedge clk); #1;
      if (acc != 0) begin idx++; if (idx < 4) begin in_state = stall_st[idx]; in_tag = 8'(8'h30 + idx); end end
      n++;
    end
    in_valid = 1'b0;
    drain();
    chk_i("stall_outputs", n_out - o0, 4);
    chk("stall_last_tag", W'(last_tg), W'(8'h33));

    // Reset with two states in flight.
    out_ready = 1'b0;
    push(rand_state(), 8'hE0);
    push(rand_state(), 8'hE1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    chk("mid_rst_out_state", out_state, '0);
    chk("mid_rst_out_tag", W'(out_tag), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;
    o0 = n_out;
    push(rand_state(), 8'h77);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk_i("post_rst_outputs", n_out - o0, 1);
    chk("post_rst_tag", W'(last_tg), W'(8'h77));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
